// File: rtl/dac_host_if.sv
// Sample handshake and DAC pin bundle for the serial DAC write host.
// The master modport is the sample source side, and the slave modport is the DAC host.
interface dac_host_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              SYNC_n;
    logic              SCLK;
    logic              DIN;
    logic              LDAC_n;
    logic              busy;
    logic              done;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  SYNC_n,
        input  SCLK,
        input  DIN,
        input  LDAC_n,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output SYNC_n,
        output SCLK,
        output DIN,
        output LDAC_n,
        output busy,
        output done
    );
endinterface

// File: rtl/dac_host.sv
// SPI-style write master for a 16-bit serial DAC.
// For each valid/ready handshake, the block takes one sample and frames it with SYNC_n.
// It shifts the sample MSB-first on a divided, registered SCLK, and it then strobes LDAC_n.
// DIN is the MSB of the shift register, so every pin comes straight from a flop.
module dac_host #(
    parameter int DATA_W        = 16,
    parameter int CLK_DIV       = 2,
    parameter int CS_SETUP      = 2,
    parameter int CS_HOLD       = 2,
    parameter int LDAC_W        = 2,
    parameter int OFFSET_BINARY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    dac_host_if.slave  bus
);

    localparam int CNT_W = 16;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ONE   = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  SETUP_END = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0]  HALF_END  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  HOLD_END  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0]  LOAD_END  = CNT_W'(LDAC_W - 1);
    localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] MSB_MASK  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

    // Converts a two's-complement sample to the code the DAC expects.
    function automatic logic [DATA_W-1:0] to_dac_code(input logic [DATA_W-1:0] sample);
        logic [DATA_W-1:0] code;
        if (OFFSET_BINARY != 0) begin
            code = sample ^ MSB_MASK;
        end else begin
            code = sample;
        end
        return code;
    endfunction

    state_t            state_r,  state_nxt_s;
    logic [CNT_W-1:0]  cnt_r,    cnt_nxt_s;
    logic [BIT_W-1:0]  bit_r,    bit_nxt_s;
    logic [DATA_W-1:0] shreg_r,  shreg_nxt_s;
    logic              sync_n_r, sync_n_nxt_s;
    logic              sclk_r,   sclk_nxt_s;
    logic              ldac_n_r, ldac_n_nxt_s;
    logic              ready_r,  ready_nxt_s;
    logic              done_r,   done_nxt_s;
    logic              busy_r;

    // State register and registered pin values; the async reset forces every pin idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            bit_r    <= BIT_ZERO;
            shreg_r  <= WORD_ZERO;
            sync_n_r <= 1'b1;
            sclk_r   <= 1'b0;
            ldac_n_r <= 1'b1;
            ready_r  <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            bit_r    <= bit_nxt_s;
            shreg_r  <= shreg_nxt_s;
            sync_n_r <= sync_n_nxt_s;
            sclk_r   <= sclk_nxt_s;
            ldac_n_r <= ldac_n_nxt_s;
            ready_r  <= ready_nxt_s;
            done_r   <= done_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    // Computes the next state and the next value of every registered pin for the frame sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        bit_nxt_s    = bit_r;
        shreg_nxt_s  = shreg_r;
        sync_n_nxt_s = sync_n_r;
        sclk_nxt_s   = sclk_r;
        ldac_n_nxt_s = ldac_n_r;
        ready_nxt_s  = ready_r;
        done_nxt_s   = 1'b0;
        if (!enable && (state_r != ST_IDLE)) begin
            // Abort: discard the partial word and truncate any LDAC pulse.
            state_nxt_s  = ST_IDLE;
            cnt_nxt_s    = CNT_ZERO;
            bit_nxt_s    = BIT_ZERO;
            shreg_nxt_s  = WORD_ZERO;
            sync_n_nxt_s = 1'b1;
            sclk_nxt_s   = 1'b0;
            ldac_n_nxt_s = 1'b1;
            ready_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_nxt_s = enable;
                    cnt_nxt_s   = CNT_ZERO;
                    if (enable && bus.data_valid && ready_r) begin
                        shreg_nxt_s  = to_dac_code(bus.data_in);
                        sync_n_nxt_s = 1'b0;
                        ready_nxt_s  = 1'b0;
                        bit_nxt_s    = BIT_ZERO;
                        state_nxt_s  = ST_SETUP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == SETUP_END) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == HALF_END) begin
                        cnt_nxt_s = CNT_ZERO;
                        if (sclk_r) begin
                            // The falling edge ends the bit period; the next bit goes out on this edge.
                            sclk_nxt_s = 1'b0;
                            if (bit_r == BIT_LAST) begin
                                bit_nxt_s   = BIT_ZERO;
                                state_nxt_s = ST_HOLD;
                            end else begin
                                bit_nxt_s   = bit_r + BIT_ONE;
                                shreg_nxt_s = {shreg_r[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            sclk_nxt_s = 1'b1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_END) begin
                        cnt_nxt_s    = CNT_ZERO;
                        sync_n_nxt_s = 1'b1;
                        ldac_n_nxt_s = 1'b0;
                        state_nxt_s  = ST_LOAD;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_LOAD: begin
                    if (cnt_r == LOAD_END) begin
                        cnt_nxt_s    = CNT_ZERO;
                        ldac_n_nxt_s = 1'b1;
                        shreg_nxt_s  = WORD_ZERO;
                        done_nxt_s   = 1'b1;
                        ready_nxt_s  = enable;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    cnt_nxt_s    = CNT_ZERO;
                    bit_nxt_s    = BIT_ZERO;
                    shreg_nxt_s  = WORD_ZERO;
                    sync_n_nxt_s = 1'b1;
                    sclk_nxt_s   = 1'b0;
                    ldac_n_nxt_s = 1'b1;
                    ready_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    assign bus.data_ready = ready_r;
    assign bus.SYNC_n     = sync_n_r;
    assign bus.SCLK       = sclk_r;
    assign bus.DIN        = shreg_r[DATA_W-1];
    assign bus.LDAC_n     = ldac_n_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_dac_host.sv
// Self-checking bench for dac_host.
// Two instances share the stimulus: one converts to offset binary and the other passes words unchanged.
// A pin-level monitor rebuilds each frame from SYNC_n/SCLK/DIN/LDAC_n/done.
// The bench then compares the rebuilt frames with the word and timing derived from the DAC framing rules.
module tb_dac_host;

    localparam int DW = 16;
    localparam int CD = 2;
    localparam int SU = 2;
    localparam int HO = 2;
    localparam int LW = 2;
    localparam int EXP_SYNC = SU + 2 * DW * CD + HO;   // SYNC_n low cycles
    localparam int EXP_LAT  = EXP_SYNC + LW;           // accept to done
    localparam int EXP_GAP  = EXP_LAT + 1;             // accept to next accept

    typedef struct {
        logic [15:0] w1;
        logic [15:0] w0;
        int          sync_c;
        int          ldac_c;
        int          rises;
        int          lat;
        logic        done0;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] din_s = 16'h0000;
    logic        valid_s = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    dac_host_if #(.DATA_W(16)) b1 ();
    dac_host_if #(.DATA_W(16)) b0 ();

    assign b1.data_in    = din_s;
    assign b1.data_valid = valid_s;
    assign b0.data_in    = din_s;
    assign b0.data_valid = valid_s;

    dac_host #(.OFFSET_BINARY(1)) dut (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(b1));
    dac_host #(.OFFSET_BINARY(0)) dut_raw (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(b0));

    always #10 clk = ~clk;

    // Monitor state
    int          cyc = 0;
    int          acc_n = 0;
    int          last_acc = 0;
    int          acc_t[$];
    rec_t        recs[$];
    int          sync_c = 0;
    int          ldac_c = 0;
    int          rise_c = 0;
    int          glitch = 0;
    logic        prev_sync = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [15:0] cap1 = 16'h0000;
    logic [15:0] cap0 = 16'h0000;

    // Records handshakes as seen on the pins and counts clock cycles.
    always @(posedge clk) begin
        if (rst_n && enable && b1.data_valid && b1.data_ready) begin
            acc_n++;
            acc_t.push_back(cyc);
            last_acc = cyc;
        end
        cyc++;
    end

    // The DAC latches DIN on SCLK rising edges.
    always @(posedge b1.SCLK) cap1 = {cap1[14:0], b1.DIN};
    always @(posedge b0.SCLK) cap0 = {cap0[14:0], b0.DIN};

    // Frame statistics sampled mid-cycle.
    always @(negedge clk) begin
        if (!b1.SYNC_n && prev_sync) begin
            sync_c = 0;
            ldac_c = 0;
            rise_c = 0;
        end
        if (!b1.SYNC_n) sync_c++;
        if (!b1.LDAC_n) ldac_c++;
        if (b1.SCLK && !prev_sclk) rise_c++;
        if (b1.SCLK && b1.SYNC_n) glitch++;
        if (b1.done === 1'b1) begin
            rec_t r;
            r.w1     = cap1;
            r.w0     = cap0;
            r.sync_c = sync_c;
            r.ldac_c = ldac_c;
            r.rises  = rise_c;
            r.lat    = cyc - 1 - last_acc;
            r.done0  = b0.done;
            recs.push_back(r);
        end
        prev_sync = b1.SYNC_n;
        prev_sclk = b1.SCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Presents one word and returns on the sample right after it is accepted.
    task automatic send(input logic [15:0] w);
        int start;
        @(negedge clk);
        din_s   = w;
        valid_s = 1'b1;
        start   = acc_n;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_n > start) break;
        end
        chk("accept", (acc_n > start), 1);
        valid_s = 1'b0;
    endtask

    // Reference: the word the DAC must receive, and the frame timing.
    task automatic check_frame(input string tag, input logic [15:0] raw);
        rec_t        r;
        logic [15:0] exp_ob;
        exp_ob = 16'(raw + 16'h8000);   // offset binary = value + half scale
        for (int i = 0; i < 400; i++) begin
            if (recs.size() > 0) break;
            @(negedge clk);
            #1;
        end
        chk({tag, "_arrived"}, (recs.size() > 0), 1);
        if (recs.size() > 0) begin
            r = recs.pop_front();
            chk({tag, "_word_ob"}, r.w1, exp_ob);
            chk({tag, "_word_raw"}, r.w0, raw);
            chk({tag, "_sync_low"}, r.sync_c, EXP_SYNC);
            chk({tag, "_ldac_low"}, r.ldac_c, LW);
            chk({tag, "_rises"}, r.rises, DW);
            chk({tag, "_latency"}, r.lat, EXP_LAT);
            chk({tag, "_done_raw"}, r.done0, 1);
        end
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_sync"}, b1.SYNC_n, 1);
        chk({tag, "_sclk"}, b1.SCLK, 0);
        chk({tag, "_din"}, b1.DIN, 0);
        chk({tag, "_ldac"}, b1.LDAC_n, 1);
        chk({tag, "_busy"}, b1.busy, 0);
        chk({tag, "_done"}, b1.done, 0);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] words[3];
        int          t0;
        int          a0;
        int          dn;
        int          r;
        logic        p;

        // Reset values
        repeat (3) @(negedge clk);
        chk_idle_pins("reset");
        chk("reset_ready", b1.data_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_enable_low", b1.data_ready, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("ready_enable_high", b1.data_ready, 1);

        // Test 1: A5C3 raw on one instance, offset binary on the other
        send(16'hA5C3);
        chk("busy_after_accept", b1.busy, 1);
        check_frame("t1", 16'hA5C3);
        chk("ready_after_done", b1.data_ready, 1);

        // Test 2: offset binary extremes
        send(16'h8000);
        check_frame("t2_min", 16'h8000);
        send(16'h7FFF);
        check_frame("t2_max", 16'h7FFF);

        // Test 3: valid held high across three words
        words[0] = 16'($urandom);
        words[1] = 16'($urandom);
        words[2] = 16'($urandom);
        t0 = acc_t.size();
        @(negedge clk);
        din_s   = words[0];
        valid_s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a0 = acc_n;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (acc_n > a0) break;
            end
            chk("t3_accept", (acc_n > a0), 1);
            if (k < 2) din_s = words[k + 1];
        end
        valid_s = 1'b0;
        if (acc_t.size() >= t0 + 3) begin
            chk("t3_gap1", acc_t[t0 + 1] - acc_t[t0], EXP_GAP);
            chk("t3_gap2", acc_t[t0 + 2] - acc_t[t0 + 1], EXP_GAP);
        end
        check_frame("t3_w0", words[0]);
        check_frame("t3_w1", words[1]);
        check_frame("t3_w2", words[2]);

        // Test 4: valid pulsed mid-frame is ignored
        w = 16'($urandom);
        send(w);
        a0 = acc_n;
        repeat (19) @(negedge clk);
        din_s   = ~w;
        valid_s = 1'b1;
        chk("t4_ready_busy", b1.data_ready, 0);
        chk("t4_busy", b1.busy, 1);
        @(negedge clk);
        valid_s = 1'b0;
        check_frame("t4", w);
        repeat (100) @(negedge clk);
        chk("t4_no_accept", acc_n, a0);
        chk("t4_no_frame", recs.size(), 0);

        // Test 5: enable dropped after the 7th SCLK rise
        w = 16'($urandom);
        send(w);
        r = 0;
        p = b1.SCLK;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b1.SCLK && !p) r++;
            p = b1.SCLK;
            if (r == 7) break;
        end
        chk("t5_seven_rises", r, 7);
        enable = 1'b0;
        @(negedge clk);
        chk_idle_pins("t5_abort");
        chk("t5_ready", b1.data_ready, 0);
        dn = recs.size();
        repeat (80) @(negedge clk);
        chk("t5_no_done", recs.size(), dn);
        enable = 1'b1;
        @(negedge clk);
        chk("t5_ready_again", b1.data_ready, 1);
        w = 16'($urandom);
        send(w);
        check_frame("t5_next", w);

        // Test 6: asynchronous reset mid-SHIFT
        w = 16'($urandom);
        send(w);
        repeat (30) @(negedge clk);
        dn = recs.size();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle_pins("t6_async");
        chk("t6_ready", b1.data_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after", b1.data_ready, 1);
        chk("t6_no_done", recs.size(), dn);

        // Random words with random idle gaps
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            w = 16'($urandom);
            send(w);
            check_frame("rand", w);
        end

        chk("sclk_while_sync_high", glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
